// File: rtl/mul6_share_arbiter.sv
// mul6_share_arbiter: shares one combinational 6x6 carry-save multiplier
// (tt_um_multi) among NREQ valid/ready requesters through a round-robin
// grant, with a single registered, backpressured, id-tagged response.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  per-requester handshake (req_ready is one-hot)
//   req_a/req_b          6-bit operands, requester i in bits [6i+5:6i]
//   rsp_valid/rsp_ready  response handshake
//   rsp_id, rsp_prod     owning requester and 12-bit product
//   busy                 state != IDLE
//   op_count             completed response handshakes, wrapping

// 3:2 compressor across a whole row: the carry vector is pre-shifted so
// x + y + z == s + c (mod 2^W).
module csa_row #(
  parameter int W = 12
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);
  logic [W-1:0] maj;
  assign s   = x ^ y ^ z;
  assign maj = (x & y) | (x & z) | (y & z);
  assign c   = {maj[W-2:0], 1'b0};
endmodule

// Unsigned 6x6 array multiplier: each partial-product row is folded into a
// sum/carry pair, one carry-propagate add at the end. Bits past 11 are
// dropped safely because the true product never exceeds 3969.
module tt_um_multi (
  input  logic [5:0]  a,
  input  logic [5:0]  b,
  output logic [11:0] p
);
  logic [5:0][11:0] pp;
  logic [6:0][11:0] s_v;
  logic [6:0][11:0] c_v;

  assign s_v[0] = '0;
  assign c_v[0] = '0;

  for (genvar gi = 0; gi < 6; gi++) begin : g_row
    assign pp[gi] = b[gi] ? ({6'b0, a} << gi) : 12'd0;
    csa_row #(.W(12)) u_row (
      .x(s_v[gi]), .y(c_v[gi]), .z(pp[gi]),
      .s(s_v[gi+1]), .c(c_v[gi+1])
    );
  end

  assign p = s_v[6] + c_v[6];
endmodule

module mul6_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [6*NREQ-1:0] req_a,
  input  logic [6*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [11:0]       rsp_prod,
  output logic              busy,
  output logic [7:0]        op_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;
  state_t state, state_nxt;

  logic [NREQ-1:0][5:0] a_arr, b_arr;
  assign a_arr = req_a;
  assign b_arr = req_b;

  logic [IDW-1:0] rr_ptr, gnt, ptr_nxt, op_id;
  logic [5:0]     op_a, op_b;
  logic [11:0]    mul_p;
  logic           found, accept;
  int             idx;

  // Rotating priority search; scanning offsets downwards lets the smallest
  // offset from rr_ptr win.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        found = 1'b1;
        gnt   = IDW'(idx);
      end
    end
  end

  assign ptr_nxt = (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
  assign accept  = (state == IDLE) && !rst && found;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt] = 1'b1;
    busy = (state != IDLE);
  end

  // Multiplier sees only registered operands.
  tt_um_multi u_mul (.a(op_a), .b(op_b), .p(mul_p));

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_prod  <= '0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_a   <= a_arr[gnt];
          op_b   <= b_arr[gnt];
          op_id  <= gnt;
          rr_ptr <= ptr_nxt;
        end
        CALC: begin
          rsp_prod  <= mul_p;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          op_count  <= op_count + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul6_share_arbiter.sv
module tb_mul6_share_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [6*NREQ-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [11:0]       rsp_prod;
  logic              busy;
  logic [7:0]        op_count;

  int n_chk  = 0;
  int n_fail = 0;

  mul6_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_prod(rsp_prod), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Reference: first valid requester found by walking from ptr modulo NREQ.
  function automatic int exp_grant(input logic [NREQ-1:0] mask, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[6*i +: 6] = 6'(i + 1);
      req_b[6*i +: 6] = 6'd1;
    end
    repeat (2) begin
      #1;
      n_chk++;
      if (req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_state: ready=%b rsp_valid=%b busy=%b op_count=%0d, want 0/0/0/0",
                 req_ready, rsp_valid, busy, op_count);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_grant: ready=%b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001; req_a[5:0] = 6'd63; req_b[5:0] = 6'd63; rsp_ready = 1'b1;
    #1;
    n_chk++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_ready: ready=%b want 0001", req_ready);
    end
    @(negedge clk);  // T+1
    req_valid = '0;
    n_chk++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_t1: rsp_valid=%b busy=%b want 0/1", rsp_valid, busy);
    end
    @(negedge clk);  // T+2
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_prod !== 12'd3969 || rsp_id !== 2'd0) begin
      n_fail++;
      $display("FAIL single_rsp: valid=%b prod=%0d id=%0d want 1/3969/0", rsp_valid, rsp_prod, rsp_id);
    end
    @(negedge clk);  // T+3
    n_chk++;
    if (op_count !== 8'd1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: op_count=%0d valid=%b busy=%b want 1/0/0", op_count, rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    int grants[$];
    int prods[$];
    int acc_cyc[$];
    int exp_g[5]  = '{0, 1, 2, 3, 0};
    int exp_pr[5] = '{2, 4, 6, 8, 2};
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[6*i +: 6] = 6'(i + 1);
      req_b[6*i +: 6] = 6'd2;
    end
    req_valid = '1; rsp_ready = 1'b1;
    for (int c = 0; c < 40 && prods.size() < 5; c++) begin
      #1;
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i]) begin grants.push_back(i); acc_cyc.push_back(c); end
      if (rsp_valid) prods.push_back(int'(rsp_prod));
      @(negedge clk);
    end
    req_valid = '0;
    n_chk++;
    if (prods.size() < 5 || grants.size() < 5) begin
      n_fail++;
      $display("FAIL rr_timeout: grants=%0d prods=%0d want >=5 each", grants.size(), prods.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_chk++;
        if (grants[k] != exp_g[k] || prods[k] != exp_pr[k]) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: grant=%0d prod=%0d want %0d/%0d",
                   k, grants[k], prods[k], exp_g[k], exp_pr[k]);
        end
        if (k > 0) begin
          n_chk++;
          if (acc_cyc[k] - acc_cyc[k-1] != 3) begin
            n_fail++;
            $display("FAIL rr_spacing[%0d]: %0d cycles want 3", k, acc_cyc[k] - acc_cyc[k-1]);
          end
        end
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int t;
    do_reset();
    req_a[5:0] = 6'd3; req_b[5:0] = 6'd5; rsp_ready = 1'b0;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '1;  // others pending; must not be granted while RESP stalls
    t = 0;
    while (!rsp_valid && t < 10) begin @(negedge clk); t++; end
    n_chk++;
    if (!rsp_valid) begin
      n_fail++;
      $display("FAIL bp_timeout: rsp_valid=%b want 1", rsp_valid);
    end
    for (int c = 0; c < 5; c++) begin
      #1;
      n_chk++;
      if (rsp_valid !== 1'b1 || rsp_prod !== 12'd15 || rsp_id !== 2'd0 ||
          req_ready !== '0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b prod=%0d id=%0d ready=%b busy=%b want 1/15/0/0000/1",
                 c, rsp_valid, rsp_prod, rsp_id, req_ready, busy);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || op_count !== 8'd1 || req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_release: busy=%b valid=%b op_count=%0d ready=%b want 0/0/1/0010",
               busy, rsp_valid, op_count, req_ready);
    end
    req_valid = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midop();
    do_reset();
    req_a[11:6] = 6'd5; req_b[11:6] = 6'd7; rsp_ready = 1'b1;
    req_valid = 4'b0010;
    #1;
    n_chk++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL midop_grant: ready=%b want 0010", req_ready);
    end
    @(negedge clk);  // CALC
    req_valid = '0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      n_chk++;
      if (rsp_valid !== 1'b0 || op_count !== 8'd0) begin
        n_fail++;
        $display("FAIL midop_quiet[%0d]: valid=%b op_count=%0d want 0/0", c, rsp_valid, op_count);
      end
      @(negedge clk);
    end
    req_valid = '1;
    #1;
    n_chk++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL midop_ptr: ready=%b want 0001", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_exhaustive();
    int done = 0;
    int t;
    do_reset();
    rsp_ready = 1'b1;
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        n_chk++;
        if (int'(op_count) != done % 256) begin
          n_fail++;
          $display("FAIL exh_count: op_count=%0d want %0d", op_count, done % 256);
        end
        req_a[17:12] = 6'(a); req_b[17:12] = 6'(b);
        req_valid = 4'b0100;
        #1;
        t = 0;
        while (!req_ready[2] && t < 10) begin @(negedge clk); #1; t++; end
        @(negedge clk);
        req_valid = '0;
        t = 0;
        while (!rsp_valid && t < 10) begin @(negedge clk); t++; end
        n_chk++;
        if (rsp_valid !== 1'b1 || int'(rsp_prod) != a * b || rsp_id !== 2'd2) begin
          n_fail++;
          $display("FAIL exh_prod a=%0d b=%0d: valid=%b prod=%0d id=%0d want 1/%0d/2",
                   a, b, rsp_valid, rsp_prod, rsp_id, a * b);
        end
        @(negedge clk);
        done++;
      end
    end
    n_chk++;
    if (op_count !== 8'd0) begin
      n_fail++;
      $display("FAIL exh_wrap: op_count=%0d want 0", op_count);
    end
  endtask

  task automatic test_random();
    int ptr = 0;
    int g, d, ea, eb;
    logic [NREQ-1:0] mask;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      mask = NREQ'($urandom_range(1, 15));
      req_a = 24'($urandom); req_b = 24'($urandom);
      d = $urandom_range(0, 3);
      g = exp_grant(mask, ptr);
      ea = int'(req_a[6*g +: 6]); eb = int'(req_b[6*g +: 6]);
      req_valid = mask; rsp_ready = 1'b0;
      #1;
      n_chk++;
      if (req_ready !== NREQ'(1 << g)) begin
        n_fail++;
        $display("FAIL rnd_grant[%0d]: ready=%b mask=%b want idx %0d", n, req_ready, mask, g);
      end
      @(negedge clk);
      req_valid = '0; req_a = 24'($urandom); req_b = 24'($urandom);
      @(negedge clk);
      n_chk++;
      if (rsp_valid !== 1'b1 || int'(rsp_prod) != ea * eb || int'(rsp_id) != g) begin
        n_fail++;
        $display("FAIL rnd_rsp[%0d]: valid=%b prod=%0d id=%0d want 1/%0d/%0d",
                 n, rsp_valid, rsp_prod, rsp_id, ea * eb, g);
      end
      repeat (d) @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      n_chk++;
      if (rsp_valid !== 1'b0 || int'(op_count) != n + 1) begin
        n_fail++;
        $display("FAIL rnd_done[%0d]: valid=%b op_count=%0d want 0/%0d", n, rsp_valid, op_count, n + 1);
      end
      ptr = (g + 1) % NREQ;
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_midop();
    test_random();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mul6_share_arbiter.md
Name: mul6_share_arbiter

Overview:
Shares one 6x6 unsigned carry-save array multiplier (tt_um_multi, instantiated inside this block) among NREQ requesters. Each requester uses a valid/ready request channel. A round-robin arbiter grants one requester at a time and registers its operands. The product goes back on a single registered response channel with backpressure, tagged with the requester index. The block sits between client engines and the combinational multiplier, so the multiplier is only ever driven from registered operands.

Parameters:
NREQ, 4, number of requesters; legal range 2..4.
IDW, 2, width of the response requester-id field; must satisfy 2^IDW >= NREQ.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  NREQ  request i has operands pending.
req_ready  out  NREQ  one-hot grant; request i is accepted when req_valid[i] and req_ready[i] are both high in the same cycle.
req_a  in  6*NREQ  operand A for requester i in bits [6i+5:6i], unsigned.
req_b  in  6*NREQ  operand B for requester i in bits [6i+5:6i], unsigned.
rsp_valid  out  1  response holds a valid product.
rsp_ready  in  1  consumer accepts the response.
rsp_id  out  IDW  index of the requester that owns the response.
rsp_prod  out  12  product a*b, unsigned, full width, no truncation.
busy  out  1  high whenever the state is not IDLE.
op_count  out  8  count of completed response handshakes; wraps 255 -> 0.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_prod=0, op_count=0, operand regs=0.
  - req_ready is combinational, so it is 0 while rst is high.
  - Reset mid-operation discards the in-flight op; no response is ever issued for it.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[g]=1 combinationally; all other req_ready bits are 0.
  - If no request is valid: req_ready=0 and the state stays IDLE.
  - On handshake: latch op_a, op_b from slice g, latch op_id=g, set rr_ptr <= (g+1) mod NREQ, go to CALC.
- CALC:
  - The multiplier is driven only from op_a/op_b.
  - At the end of the cycle: rsp_prod <= multiplier output, rsp_id <= op_id, rsp_valid <= 1, go to RESP.
  - req_ready = 0.
- RESP:
  - rsp_valid, rsp_id and rsp_prod stay stable until rsp_ready=1.
  - On the rsp_valid & rsp_ready handshake: rsp_valid <= 0, op_count <= op_count+1 (wrapping), go to IDLE.
  - req_ready = 0.
- Latency and throughput:
  - Request handshake in cycle T -> rsp_valid high from cycle T+2.
  - With rsp_ready held high, the next accept is in cycle T+3, so peak throughput is one op per 3 cycles.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ grants.
- A requester deasserting req_valid before its grant is legal; that request is simply not served. Operands are sampled only in the handshake cycle.
- rsp_ready asserted while rsp_valid=0 has no effect.
- op_count increments only on a response handshake, never on a request handshake.
- Arithmetic: rsp_prod = op_a * op_b over the 12-bit range 0..3969; tt_um_multi must match this exactly.

Test Plan:
1. Reset: hold rst 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, busy=0, op_count=0; first grant after release goes to requester 0.
2. Single op: req_valid[0]=1, a=63, b=63, rsp_ready=1.
   - Handshake in cycle T -> rsp_valid=1 in T+2 with rsp_prod=3969 (0xF81), rsp_id=0.
   - op_count=1 after the response handshake.
3. Round-robin: all 4 req_valid held high, requester i driving a=i+1, b=2, rsp_ready=1.
   - Grants observed in order 0,1,2,3,0.
   - Products observed in order 2,4,6,8,2.
   - One accept every 3 cycles.
4. Backpressure: complete one op, then hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_id/rsp_prod constant, req_ready=0 throughout, busy=1; rsp_ready=1 -> IDLE next cycle.
5. Reset mid-op: accept a=5, b=7 from requester 1, assert rst during CALC -> rsp_valid never rises, rr_ptr=0, op_count=0.
6. Exhaustive/wrap: all 4096 (a,b) pairs through requester 2 -> every rsp_prod = a*b, every rsp_id=2; op_count equals completed ops mod 256 (4096 ops end at 0).
